// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared segment codes, level encodings and BCD types for the score display
package score_disp_pkg;

    typedef logic [3:0] bcd_nibble_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_L     = 8'h38;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [2:0] LEVEL_1 = 3'b001;
    localparam logic [2:0] LEVEL_2 = 3'b010;
    localparam logic [2:0] LEVEL_3 = 3'b100;

    function automatic logic [7:0] seg_encode(input bcd_nibble_t n);
        case (n)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 7-bit sequential shift-add-3 binary to BCD converter with start/done handshake
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  bin,
    output logic        done,
    output bcd_nibble_t bcd_hund,
    output bcd_nibble_t bcd_tens,
    output bcd_nibble_t bcd_unit
);

    logic [6:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic [11:0] adj;
    logic [11:0] shifted;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted  = {adj[10:0], bin_q[6]};
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            bin_d    = bin;
            bcd_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d = shifted;
            bin_d = {bin_q[5:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
                active_d = 1'b0;
            end
        end
    end

    assign done = active_q && (cnt_q == 3'd6);
    assign {bcd_hund, bcd_tens, bcd_unit} = shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/score_display_7seg.sv
// rtl/score_display_7seg.sv - score/round/level 8-digit multiplexed 7-segment display driver with blink
module score_display_7seg
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 500
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    input  logic [4:0] round_count,
    input  logic [2:0] level,
    input  logic       game_end,
    output logic       busy,
    output logic [7:0] SEG_COM,
    output logic [7:0] SEG_DATA
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_CONV_SCORE = 2'd1;
    localparam logic [1:0] ST_CONV_ROUND = 2'd2;
    localparam logic [1:0] ST_COMMIT     = 2'd3;

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [1:0]   state_q, state_d;
    logic [6:0]   snap_score_q, snap_score_d;
    logic [4:0]   snap_round_q, snap_round_d;
    bcd_nibble_t  hold_shund_q, hold_shund_d, hold_stens_q, hold_stens_d, hold_sunit_q, hold_sunit_d;
    bcd_nibble_t  hold_rtens_q, hold_rtens_d, hold_runit_q, hold_runit_d;
    bcd_nibble_t  disp_shund_q, disp_shund_d, disp_stens_q, disp_stens_d, disp_sunit_q, disp_sunit_d;
    bcd_nibble_t  disp_rtens_q, disp_rtens_d, disp_runit_q, disp_runit_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [7:0]   seg_com_q, seg_com_d, seg_data_q, seg_data_d;
    logic [7:0]   digit_seg;

    logic         conv_start;
    logic [6:0]   conv_bin;
    logic         conv_done;
    bcd_nibble_t  conv_hund, conv_tens, conv_unit;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      (conv_bin),
        .done     (conv_done),
        .bcd_hund (conv_hund),
        .bcd_tens (conv_tens),
        .bcd_unit (conv_unit)
    );

    always_comb begin
        state_d      = state_q;
        snap_score_d = snap_score_q;
        snap_round_d = snap_round_q;
        hold_shund_d = hold_shund_q;
        hold_stens_d = hold_stens_q;
        hold_sunit_d = hold_sunit_q;
        hold_rtens_d = hold_rtens_q;
        hold_runit_d = hold_runit_q;
        disp_shund_d = disp_shund_q;
        disp_stens_d = disp_stens_q;
        disp_sunit_d = disp_sunit_q;
        disp_rtens_d = disp_rtens_q;
        disp_runit_d = disp_runit_q;
        conv_start   = 1'b0;
        conv_bin     = score;
        case (state_q)
            ST_IDLE: begin
                if ((score != snap_score_q) || (round_count != snap_round_q)) begin
                    snap_score_d = score;
                    snap_round_d = round_count;
                    conv_start   = 1'b1;
                    conv_bin     = score;
                    state_d      = ST_CONV_SCORE;
                end
            end
            ST_CONV_SCORE: begin
                if (conv_done) begin
                    hold_shund_d = conv_hund;
                    hold_stens_d = conv_tens;
                    hold_sunit_d = conv_unit;
                    conv_start   = 1'b1;
                    conv_bin     = {2'b00, snap_round_q};
                    state_d      = ST_CONV_ROUND;
                end
            end
            ST_CONV_ROUND: begin
                if (conv_done) begin
                    hold_rtens_d = conv_tens;
                    hold_runit_d = conv_unit;
                    state_d      = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_shund_d = hold_shund_q;
                disp_stens_d = hold_stens_q;
                disp_sunit_d = hold_sunit_q;
                disp_rtens_d = hold_rtens_q;
                disp_runit_d = hold_runit_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 3'd1;
        end
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (game_end) begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blink_on_d  = blink_on_q;
            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end
        end
        case (digit_idx_q)
            3'd7: digit_seg = SEG_L;
            3'd6: begin
                case (level)
                    LEVEL_1: digit_seg = SEG_1;
                    LEVEL_2: digit_seg = SEG_2;
                    LEVEL_3: digit_seg = SEG_3;
                    default: digit_seg = SEG_BLANK;
                endcase
            end
            3'd5: digit_seg = SEG_BLANK;
            3'd4: digit_seg = (disp_rtens_q == 4'd0) ? SEG_BLANK : seg_encode(disp_rtens_q);
            3'd3: digit_seg = seg_encode(disp_runit_q);
            3'd2: digit_seg = (disp_shund_q == 4'd0) ? SEG_BLANK : seg_encode(disp_shund_q);
            3'd1: digit_seg = ((disp_shund_q == 4'd0) && (disp_stens_q == 4'd0)) ? SEG_BLANK
                                                                                 : seg_encode(disp_stens_q);
            default: digit_seg = seg_encode(disp_sunit_q);
        endcase
        seg_com_d  = ~(8'b0000_0001 << digit_idx_q);
        seg_data_d = blink_on_q ? digit_seg : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            snap_score_q <= '0;
            snap_round_q <= '0;
            hold_shund_q <= '0;
            hold_stens_q <= '0;
            hold_sunit_q <= '0;
            hold_rtens_q <= '0;
            hold_runit_q <= '0;
            disp_shund_q <= '0;
            disp_stens_q <= '0;
            disp_sunit_q <= '0;
            disp_rtens_q <= '0;
            disp_runit_q <= '0;
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            seg_com_q    <= 8'hFF;
            seg_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            snap_score_q <= snap_score_d;
            snap_round_q <= snap_round_d;
            hold_shund_q <= hold_shund_d;
            hold_stens_q <= hold_stens_d;
            hold_sunit_q <= hold_sunit_d;
            hold_rtens_q <= hold_rtens_d;
            hold_runit_q <= hold_runit_d;
            disp_shund_q <= disp_shund_d;
            disp_stens_q <= disp_stens_d;
            disp_sunit_q <= disp_sunit_d;
            disp_rtens_q <= disp_rtens_d;
            disp_runit_q <= disp_runit_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            seg_com_q    <= seg_com_d;
            seg_data_q   <= seg_data_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign SEG_COM  = seg_com_q;
    assign SEG_DATA = seg_data_q;

endmodule

// File: tb/tb_score_display_7seg.sv
// tb/tb_score_display_7seg.sv - directed self-checking bench for score_display_7seg
module tb_score_display_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] score = 7'd0;
    logic [4:0] round_count = 5'd0;
    logic [2:0] level = 3'b001;
    logic       game_end = 1'b0;
    logic       busy;
    logic [7:0] SEG_COM;
    logic [7:0] SEG_DATA;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] disp [8];
    logic [7:0] exp_seg [8];

    score_display_7seg #(.SCAN_DIV(1), .BLINK_HALF(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .round_count (round_count),
        .level       (level),
        .game_end    (game_end),
        .busy        (busy),
        .SEG_COM     (SEG_COM),
        .SEG_DATA    (SEG_DATA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic capture();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            disp[(cyc - 1) & 7] = SEG_DATA;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (SEG_COM !== 8'hFF) begin fails++; $display("FAIL reset_com got %h want ff", SEG_COM); end
        tests++;
        if (SEG_DATA !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", SEG_DATA); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        capture();
        exp_seg = '{8'h3F, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h06, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL reset_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_convert();
        int first = -1;
        int last = -1;
        score = 7'd70; round_count = 5'd10; level = 3'b010;
        for (int s = 1; s <= 17; s++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (first < 0) first = s;
                last = s;
            end
        end
        tests++;
        if (first != 1) begin fails++; $display("FAIL conv_busy_first got %0d want 1", first); end
        tests++;
        if (last != 15) begin fails++; $display("FAIL conv_busy_last got %0d want 15", last); end
        capture();
        exp_seg = '{8'h3F, 8'h07, 8'h00, 8'h3F, 8'h06, 8'h00, 8'h5B, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL conv70_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_hundred();
        score = 7'd100; round_count = 5'd9; level = 3'b100;
        repeat (17) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL hund_busy got %b want 0", busy); end
        capture();
        exp_seg = '{8'h3F, 8'h3F, 8'h06, 8'h6F, 8'h00, 8'h00, 8'h4F, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL hund_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_level_invalid();
        level = 3'b011;
        capture();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL lvl_busy got %b want 0", busy); end
        exp_seg = '{8'h3F, 8'h3F, 8'h06, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL lvl_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_restart();
        score = 7'd20;
        repeat (17) @(negedge clk);
        score = 7'd30;
        for (int s = 1; s <= 32; s++) begin
            @(negedge clk);
            if (s == 5) score = 7'd40;
            if (s == 16) begin
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL restart_busy16 got %b want 0", busy); end
            end
            if (s == 17 || s == 31) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy%0d got %b want 1", s, busy); end
            end
            if (s == 32) begin
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL restart_busy32 got %b want 0", busy); end
            end
            if (s >= 17 && s <= 24) disp[(cyc - 1) & 7] = SEG_DATA;
        end
        exp_seg = '{8'h3F, 8'h4F, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL restart30_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
        capture();
        exp_seg = '{8'h3F, 8'h66, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL restart40_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] one = 8'h01;
        logic [7:0] exp_com;
        logic [7:0] exp_data;
        int idx;
        bit on;
        exp_seg = '{8'h3F, 8'h66, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h06, 8'h38};
        level = 3'b001;
        game_end = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            idx = (cyc - 1) & 7;
            on = (s <= 4) || (s >= 9 && s <= 12) || (s >= 16);
            exp_com = ~(one << idx);
            exp_data = on ? exp_seg[idx] : 8'h00;
            tests++;
            if (SEG_COM !== exp_com) begin
                fails++; $display("FAIL blink_com s%0d got %h want %h", s, SEG_COM, exp_com);
            end
            tests++;
            if (SEG_DATA !== exp_data) begin
                fails++; $display("FAIL blink_data s%0d got %h want %h", s, SEG_DATA, exp_data);
            end
            if (s == 14) game_end = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        score = 7'd55; round_count = 5'd17;
        repeat (8) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre got %b want 1", busy); end
        rst = 1'b1; score = 7'd0; round_count = 5'd0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_rst got %b want 0", busy); end
        tests++;
        if (SEG_COM !== 8'hFF) begin fails++; $display("FAIL mid_com_rst got %h want ff", SEG_COM); end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_idle got %b want 0", busy); end
        capture();
        exp_seg = '{8'h3F, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h06, 8'h38};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (disp[i] !== exp_seg[i]) begin
                fails++; $display("FAIL mid_digit%0d got %h want %h", i, disp[i], exp_seg[i]);
            end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_end got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_hundred();
        test_level_invalid();
        test_restart();
        test_blink();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
